spi_frame_ctrl: RTL and testbench



---
 rtl/spi_frame_pkg.sv | 19 +
 rtl/spi_frame_ctrl_shifter.sv | 26 ++
 rtl/spi_frame_ctrl.sv | 116 +++++++++++
 tb/tb_spi_frame_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared types, constants and the address wrap rule for the SPI frame controller.
package spi_frame_pkg;

    localparam int CMD_WRITE_BIT = 7;
    localparam int ADDR_W        = 7;

    typedef enum logic [1:0] {
        CMD   = 2'd0,
        WDATA = 2'd1,
        RDATA = 2'd2
    } state_t;

    // Walks forward one register; the top valid address wraps back to 1.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] cur,
                                                     input logic [ADDR_W-1:0] max);
        return (cur == max) ? ADDR_W'(1) : cur + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/spi_frame_ctrl_shifter.sv
// Bit counter and PICO deserialiser; byte_val is the byte that completes this edge.
module spi_byte_shifter (
    input  logic       spi_clk,
    input  logic       full_rstn,
    input  logic       pico,
    output logic       byte_done,
    output logic [7:0] byte_val
);

    logic [2:0] bit_cnt;
    logic [6:0] shift_in;

    always_ff @(posedge spi_clk or negedge full_rstn) begin
        if (!full_rstn) begin
            bit_cnt  <= 3'd0;
            shift_in <= 7'd0;
        end else begin
            bit_cnt  <= bit_cnt + 3'd1;
            shift_in <= {shift_in[5:0], pico};
        end
    end

    assign byte_done = (bit_cnt == 3'd7);
    assign byte_val  = {shift_in, pico};

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI transaction sequencer: command byte, then register writes or a serialised read burst.
module spi_frame_ctrl
    import spi_frame_pkg::*;
#(
    parameter int MAX_ADDR    = 10,
    parameter int WR_MAX_ADDR = 9,
    parameter int AUTO_INC    = 1
) (
    input  logic              spi_clk,
    input  logic              full_rstn,
    input  logic              pico,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wdata,
    output logic              wr_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_req,
    input  logic [7:0]        rd_data,
    output logic              poci,
    output logic              frame_err,
    output logic [7:0]        byte_count,
    output state_t            state
);

    localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);
    localparam logic [ADDR_W-1:0] WR_A  = ADDR_W'(WR_MAX_ADDR);

    logic              byte_done;
    logic [7:0]        byte_val;
    logic [ADDR_W-1:0] cur_addr;
    logic [6:0]        shift_out;
    logic [ADDR_W-1:0] ld_addr;
    logic              rd_ok;
    logic              wr_ok;
    logic [7:0]        ld_data;

    spi_byte_shifter u_shifter (
        .spi_clk   (spi_clk),
        .full_rstn (full_rstn),
        .pico      (pico),
        .byte_done (byte_done),
        .byte_val  (byte_val)
    );

    function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] a);
        return (AUTO_INC != 0) ? next_addr(a, MAX_A) : a;
    endfunction

    // The command edge reads the start address straight off the shifter.
    assign ld_addr = (state == CMD) ? byte_val[ADDR_W-1:0] : cur_addr;
    assign rd_addr = ld_addr;
    assign rd_req  = byte_done && ((state == RDATA) ||
                                   (state == CMD && !byte_val[CMD_WRITE_BIT]));
    assign rd_ok   = (ld_addr != '0) && (ld_addr <= MAX_A);
    assign ld_data = rd_ok ? rd_data : 8'h00;
    assign wr_ok   = (cur_addr != '0) && (cur_addr <= WR_A);

    always_ff @(posedge spi_clk or negedge full_rstn) begin
        if (!full_rstn) begin
            state      <= CMD;
            cur_addr   <= '0;
            shift_out  <= '0;
            wr_addr    <= '0;
            wdata      <= '0;
            wr_en      <= 1'b0;
            poci       <= 1'b0;
            frame_err  <= 1'b0;
            byte_count <= '0;
        end else begin
            wr_en <= 1'b0;
            if (byte_done && byte_count != 8'hFF)
                byte_count <= byte_count + 8'd1;
            case (state)
                CMD: begin
                    if (byte_done) begin
                        if (byte_val[CMD_WRITE_BIT]) begin
                            state    <= WDATA;
                            cur_addr <= byte_val[ADDR_W-1:0];
                        end else begin
                            state     <= RDATA;
                            cur_addr  <= step(byte_val[ADDR_W-1:0]);
                            shift_out <= ld_data[6:0];
                            poci      <= ld_data[7];
                            if (!rd_ok) frame_err <= 1'b1;
                        end
                    end
                end
                WDATA: begin
                    poci <= 1'b0;
                    if (byte_done) begin
                        if (wr_ok) begin
                            wr_en   <= 1'b1;
                            wr_addr <= cur_addr;
                            wdata   <= byte_val;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        cur_addr <= step(cur_addr);
                    end
                end
                RDATA: begin
                    if (byte_done) begin
                        shift_out <= ld_data[6:0];
                        poci      <= ld_data[7];
                        cur_addr  <= step(cur_addr);
                        if (!rd_ok) frame_err <= 1'b1;
                    end else begin
                        poci      <= shift_out[6];
                        shift_out <= {shift_out[5:0], 1'b0};
                    end
                end
                default: state <= CMD;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Bench for spi_frame_ctrl: one auto-increment and one address-hold instance share the SPI pins.
module tb_spi_frame_ctrl;
    import spi_frame_pkg::*;

    logic       spi_clk = 1'b0;
    logic       full_rstn = 1'b0;
    logic       pico = 1'b0;
    logic [6:0] wr_addr_a, rd_addr_a, wr_addr_h, rd_addr_h;
    logic [7:0] wdata_a, rd_data_a, byte_count_a, wdata_h, rd_data_h, byte_count_h;
    logic       wr_en_a, rd_req_a, poci_a, frame_err_a;
    logic       wr_en_h, rd_req_h, poci_h, frame_err_h;
    state_t     state_a, state_h;

    logic [7:0] regs [0:127];
    logic [7:0] fb [0:299];
    logic [6:0] atab [0:1][0:299];
    int         checks = 0;
    int         errors = 0;
    int         strobes_a, strobes_h;
    logic [6:0] saddr_h [$];
    logic [7:0] sdata_h [$];
    logic [6:0] saddr_a [$];
    logic       poci_q [$];

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_h = regs[rd_addr_h];

    spi_frame_ctrl #(.MAX_ADDR(10), .WR_MAX_ADDR(9), .AUTO_INC(1)) dut (
        .spi_clk(spi_clk), .full_rstn(full_rstn), .pico(pico),
        .wr_addr(wr_addr_a), .wdata(wdata_a), .wr_en(wr_en_a),
        .rd_addr(rd_addr_a), .rd_req(rd_req_a), .rd_data(rd_data_a),
        .poci(poci_a), .frame_err(frame_err_a), .byte_count(byte_count_a),
        .state(state_a)
    );

    spi_frame_ctrl #(.MAX_ADDR(10), .WR_MAX_ADDR(9), .AUTO_INC(0)) dut_hold (
        .spi_clk(spi_clk), .full_rstn(full_rstn), .pico(pico),
        .wr_addr(wr_addr_h), .wdata(wdata_h), .wr_en(wr_en_h),
        .rd_addr(rd_addr_h), .rd_req(rd_req_h), .rd_data(rd_data_h),
        .poci(poci_h), .frame_err(frame_err_h), .byte_count(byte_count_h),
        .state(state_h)
    );

    always #5 spi_clk = ~spi_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] adv(input logic [6:0] a);
        return (a == 7'd10) ? 7'd1 : 7'(a + 7'd1);
    endfunction

    function automatic logic valid_rd(input logic [6:0] a);
        return (a >= 7'd1) && (a <= 7'd10);
    endfunction

    function automatic logic valid_wr(input logic [6:0] a);
        return (a >= 7'd1) && (a <= 7'd9);
    endfunction

    // Address used by the d-th data access of the frame, for each increment mode.
    task automatic build_tab();
        for (int inc = 0; inc < 2; inc++) begin
            atab[inc][0] = fb[0][6:0];
            for (int d = 1; d < 300; d++)
                atab[inc][d] = (inc == 1) ? adv(atab[inc][d-1]) : atab[inc][d-1];
        end
    endtask

    task automatic expect_at(input int inc, input int k, output logic e_wr,
                             output logic [6:0] e_wa, output logic [7:0] e_wd,
                             output logic e_poci, output logic e_err, output int e_bc);
        int nb;
        int ml;
        int bi;
        logic [7:0] dv;
        nb = k / 8;
        e_wr = 0; e_wa = 0; e_wd = 0; e_poci = 0; e_err = 0;
        e_bc = (nb > 255) ? 255 : nb;
        if (nb >= 1) begin
            if (fb[0][7]) begin
                for (int d = 0; d < nb - 1; d++)
                    if (!valid_wr(atab[inc][d])) e_err = 1;
                if (k % 8 == 0 && nb >= 2 && valid_wr(atab[inc][nb-2])) begin
                    e_wr = 1;
                    e_wa = atab[inc][nb-2];
                    e_wd = fb[nb-1];
                end
            end else begin
                ml = (k - 8) / 8;
                bi = (k - 8) % 8;
                for (int m = 0; m <= ml; m++)
                    if (!valid_rd(atab[inc][m])) e_err = 1;
                dv = valid_rd(atab[inc][ml]) ? regs[atab[inc][ml]] : 8'h00;
                e_poci = dv[7 - bi];
            end
        end
    endtask

    task automatic check_cycle(input int k);
        logic e_wr, e_p, e_e;
        logic [6:0] e_wa;
        logic [7:0] e_wd;
        int e_bc;
        expect_at(1, k, e_wr, e_wa, e_wd, e_p, e_e, e_bc);
        chk("inc_wr_en", 32'(wr_en_a), 32'(e_wr));
        if (e_wr) begin
            chk("inc_wr_addr", 32'(wr_addr_a), 32'(e_wa));
            chk("inc_wdata", 32'(wdata_a), 32'(e_wd));
        end
        chk("inc_poci", 32'(poci_a), 32'(e_p));
        chk("inc_frame_err", 32'(frame_err_a), 32'(e_e));
        chk("inc_byte_count", 32'(byte_count_a), 32'(e_bc));
        if (wr_en_a) begin strobes_a++; saddr_a.push_back(wr_addr_a); end
        poci_q.push_back(poci_a);
        expect_at(0, k, e_wr, e_wa, e_wd, e_p, e_e, e_bc);
        chk("hold_wr_en", 32'(wr_en_h), 32'(e_wr));
        if (e_wr) begin
            chk("hold_wr_addr", 32'(wr_addr_h), 32'(e_wa));
            chk("hold_wdata", 32'(wdata_h), 32'(e_wd));
        end
        chk("hold_poci", 32'(poci_h), 32'(e_p));
        chk("hold_frame_err", 32'(frame_err_h), 32'(e_e));
        chk("hold_byte_count", 32'(byte_count_h), 32'(e_bc));
        if (wr_en_h) begin strobes_h++; saddr_h.push_back(wr_addr_h); sdata_h.push_back(wdata_h); end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en_a), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr_a), 0);
        chk({tag, "_wdata"}, 32'(wdata_a), 0);
        chk({tag, "_poci"}, 32'(poci_a), 0);
        chk({tag, "_frame_err"}, 32'(frame_err_a), 0);
        chk({tag, "_byte_count"}, 32'(byte_count_a), 0);
        chk({tag, "_state"}, 32'(state_a), 32'(CMD));
        chk({tag, "_hold_byte_count"}, 32'(byte_count_h), 0);
    endtask

    // Holds chip select low across at least one clock edge; the next frame releases it.
    task automatic do_reset();
        @(negedge spi_clk);
        full_rstn = 1'b0;
        pico = 1'($urandom_range(0, 1));
        #1 check_idle("reset");
        @(posedge spi_clk);
        #1 check_idle("reset_hold");
    endtask

    task automatic load_frame(input logic [31:0] b, input int nb);
        for (int i = 0; i < 300; i++) fb[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) fb[i] = b[31-8*i -: 8];
        if (nb < 4) for (int i = nb; i < 4; i++) fb[i] = 8'($urandom);
    endtask

    task automatic run_frame(input int nbits);
        logic e_rd;
        build_tab();
        strobes_a = 0; strobes_h = 0;
        saddr_a.delete(); saddr_h.delete(); sdata_h.delete(); poci_q.delete();
        for (int k = 1; k <= nbits; k++) begin
            @(negedge spi_clk);
            full_rstn = 1'b1;
            pico = fb[(k-1)/8][7 - ((k-1) % 8)];
            #1;
            e_rd = (k % 8 == 0) && !fb[0][7];
            chk("inc_rd_req", 32'(rd_req_a), 32'(e_rd));
            chk("hold_rd_req", 32'(rd_req_h), 32'(e_rd));
            if (e_rd) begin
                chk("inc_rd_addr", 32'(rd_addr_a), 32'(atab[1][k/8-1]));
                chk("hold_rd_addr", 32'(rd_addr_h), 32'(atab[0][k/8-1]));
            end
            @(posedge spi_clk);
            #1 check_cycle(k);
        end
    endtask

    typedef struct packed {
        logic [31:0] bytes;
        logic [7:0]  nbytes;
        logic [7:0]  exp_strobes;
        logic        exp_err;
        logic [7:0]  exp_bc;
    } vec_t;

    vec_t vecs [10];
    logic [7:0] rb;

    initial begin
        vecs[0] = '{32'h82A5_0000, 8'd2, 8'd1, 1'b0, 8'd2};
        vecs[1] = '{32'h8811_2233, 8'd4, 8'd2, 1'b1, 8'd4};
        vecs[2] = '{32'h0900_0000, 8'd4, 8'd0, 1'b0, 8'd4};
        vecs[3] = '{32'h0C00_0000, 8'd2, 8'd0, 1'b1, 8'd2};
        vecs[4] = '{32'h8302_0000, 8'd2, 8'd1, 1'b0, 8'd2};
        vecs[5] = '{32'h85F0_0F00, 8'd3, 8'd2, 1'b0, 8'd3};
        vecs[6] = '{32'h8055_0000, 8'd2, 8'd0, 1'b1, 8'd2};
        vecs[7] = '{32'h8A77_0000, 8'd2, 8'd0, 1'b1, 8'd2};
        vecs[8] = '{32'h0000_0000, 8'd1, 8'd0, 1'b1, 8'd1};
        vecs[9] = '{32'h0A00_0000, 8'd3, 8'd0, 1'b0, 8'd3};
        for (int i = 0; i < 128; i++) regs[i] = 8'($urandom);

        repeat (2) @(posedge spi_clk);
        for (int v = 0; v < 10; v++) begin
            do_reset();
            load_frame(vecs[v].bytes, int'(vecs[v].nbytes));
            run_frame(8 * int'(vecs[v].nbytes));
            chk("tbl_strobes", 32'(strobes_a), 32'(vecs[v].exp_strobes));
            chk("tbl_frame_err", 32'(frame_err_a), 32'(vecs[v].exp_err));
            chk("tbl_byte_count", 32'(byte_count_a), 32'(vecs[v].exp_bc));
        end

        // Burst write from 8: strobes land on 8 and 9 only.
        do_reset();
        load_frame(32'h8811_2233, 4);
        run_frame(32);
        chk("burst_n", 32'(saddr_a.size()), 2);
        if (saddr_a.size() == 2) begin
            chk("burst_addr0", 32'(saddr_a[0]), 8);
            chk("burst_addr1", 32'(saddr_a[1]), 9);
        end

        // Read burst wrapping 10 -> 1.
        regs[9] = 8'h01; regs[10] = 8'h01; regs[1] = 8'h3F;
        do_reset();
        load_frame(32'h0900_0000, 4);
        run_frame(32);
        for (int m = 0; m < 3; m++) begin
            rb = '0;
            for (int b = 0; b < 8; b++) rb = {rb[6:0], poci_q[7 + 8*m + b]};
            chk("rdburst_byte", 32'(rb), (m == 2) ? 32'h3F : 32'h01);
        end

        // Hold mode writes both bytes to address 5.
        do_reset();
        load_frame(32'h85F0_0F00, 3);
        run_frame(24);
        chk("hold_n", 32'(saddr_h.size()), 2);
        if (saddr_h.size() == 2) begin
            chk("hold_addr0", 32'(saddr_h[0]), 5);
            chk("hold_addr1", 32'(saddr_h[1]), 5);
            chk("hold_data0", 32'(sdata_h[0]), 32'hF0);
            chk("hold_data1", 32'(sdata_h[1]), 32'h0F);
        end

        // Chip select drops after 12 bits, then a clean frame follows.
        do_reset();
        load_frame(32'h8302_0000, 2);
        run_frame(12);
        chk("abort_strobes", 32'(strobes_a), 0);
        do_reset();
        load_frame(32'h8302_0000, 2);
        run_frame(16);
        chk("after_abort_n", 32'(saddr_a.size()), 1);
        if (saddr_a.size() == 1) chk("after_abort_addr", 32'(saddr_a[0]), 3);

        // Long read frame saturates the byte counter.
        do_reset();
        load_frame(32'h0100_0000, 1);
        run_frame(8 * 260);
        chk("sat_byte_count", 32'(byte_count_a), 255);

        // Random frames against the model.
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < 128; i++) regs[i] = 8'($urandom);
            do_reset();
            load_frame($urandom, 4);
            fb[0][6:0] = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(11, 127))
                                                      : 7'($urandom_range(0, 12));
            run_frame($urandom_range(8, 48));
        end

        do_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
